// File: rtl/ram_byte_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ram_byte_seq : turns one byte/half/word LSU request into byte-wide RAM
//                accesses and returns a single little-endian response pulse.
// Revision     : 1.0  initial release
// ============================================================================
module ram_byte_seq #(
   parameter int DEPTH = 32,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst_enm,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [7:0]    mem_wdata,
   output logic [AW-1:0] mem_addr,
   input  logic [31:0]   mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR    = 3'd1,
      S_RD    = 3'd2,
      S_DRAIN = 3'd3,
      S_RSP   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [1:0]      size_q, size_d;
   logic            we_q, we_d;
   logic            uns_q, uns_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     asm_q, asm_d;
   logic            err_q, err_d;
   logic            mem_rd_q, mem_rd_d;
   logic            mem_wr_q, mem_wr_d;
   logic [7:0]      mem_wdata_q, mem_wdata_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;

   logic [2:0]      w_req_n;
   logic [AW:0]     w_req_last;
   logic            w_req_err;
   logic            w_accept;
   logic [1:0]      w_last_idx;
   logic [1:0]      w_cnt_nxt;
   logic [1:0]      w_cap_idx;
   logic [AW-1:0]   w_addr_nxt;
   logic [31:0]     w_ext;
   logic            w_unused;

   // Only the low byte of the RAM read bus carries data.
   assign w_unused   = ^mem_rdata[31:8];

   assign req_ready  = (state_q == S_IDLE) && !rst_enm;
   assign w_accept   = req_valid && req_ready;

   always_comb begin
      case (req_size)
         2'b01:   w_req_n = 3'd2;
         2'b10:   w_req_n = 3'd4;
         default: w_req_n = 3'd1;
      endcase
   end

   // One extra bit keeps the last-byte address from wrapping before the range test.
   assign w_req_last = {1'b0, req_addr} + {{(AW-2){1'b0}}, w_req_n} - {{AW{1'b0}}, 1'b1};
   assign w_req_err  = (req_size == 2'b11)
                    || ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                    || (w_req_last >= (AW+1)'(DEPTH));

   always_comb begin
      case (size_q)
         2'b00:   w_last_idx = 2'd0;
         2'b01:   w_last_idx = 2'd1;
         default: w_last_idx = 2'd3;
      endcase
   end

   assign w_cnt_nxt  = cnt_q + 2'd1;
   assign w_cap_idx  = cnt_q - 2'd1;
   assign w_addr_nxt = addr_q + {{(AW-2){1'b0}}, w_cnt_nxt};

   always_comb begin
      case (size_q)
         2'b00:   w_ext = {{24{asm_q[7]  & ~uns_q}}, asm_q[7:0]};
         2'b01:   w_ext = {{16{asm_q[15] & ~uns_q}}, asm_q[15:0]};
         default: w_ext = asm_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      size_d      = size_q;
      we_d        = we_q;
      uns_d       = uns_q;
      wdata_d     = wdata_q;
      asm_d       = asm_q;
      err_d       = err_q;
      mem_rd_d    = 1'b0;
      mem_wr_d    = 1'b0;
      mem_wdata_d = 8'd0;
      mem_addr_d  = mem_addr_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               addr_d  = req_addr;
               size_d  = req_size;
               we_d    = req_we;
               uns_d   = req_unsigned;
               wdata_d = req_wdata;
               asm_d   = 32'd0;
               cnt_d   = 2'd0;
               err_d   = w_req_err;
               if (w_req_err) begin
                  state_d = S_RSP;
               end else begin
                  mem_addr_d = req_addr;
                  if (req_we) begin
                     mem_wr_d    = 1'b1;
                     mem_wdata_d = req_wdata[7:0];
                     state_d     = S_WR;
                  end else begin
                     mem_rd_d = 1'b1;
                     state_d  = S_RD;
                  end
               end
            end
         end
         S_WR: begin
            if (cnt_q == w_last_idx) begin
               state_d = S_RSP;
            end else begin
               cnt_d       = w_cnt_nxt;
               mem_wr_d    = 1'b1;
               mem_addr_d  = w_addr_nxt;
               mem_wdata_d = wdata_q[{w_cnt_nxt, 3'b000} +: 8];
            end
         end
         S_RD: begin
            // Read data lags its issue by one cycle, so capture the previous byte.
            if (cnt_q != 2'd0) begin
               asm_d[{w_cap_idx, 3'b000} +: 8] = mem_rdata[7:0];
            end
            if (cnt_q == w_last_idx) begin
               state_d = S_DRAIN;
            end else begin
               cnt_d      = w_cnt_nxt;
               mem_rd_d   = 1'b1;
               mem_addr_d = w_addr_nxt;
            end
         end
         S_DRAIN: begin
            asm_d[{cnt_q, 3'b000} +: 8] = mem_rdata[7:0];
            state_d = S_RSP;
         end
         S_RSP: begin
            cnt_d   = 2'd0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_enm) begin
         state_q     <= S_IDLE;
         cnt_q       <= 2'd0;
         addr_q      <= '0;
         size_q      <= 2'd0;
         we_q        <= 1'b0;
         uns_q       <= 1'b0;
         wdata_q     <= 32'd0;
         asm_q       <= 32'd0;
         err_q       <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_wdata_q <= 8'd0;
         mem_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         we_q        <= we_d;
         uns_q       <= uns_d;
         wdata_q     <= wdata_d;
         asm_q       <= asm_d;
         err_q       <= err_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_addr_q  <= mem_addr_d;
      end
   end

   assign mem_rd    = mem_rd_q;
   assign mem_wr    = mem_wr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_addr  = mem_addr_q;

   assign rsp_valid = (state_q == S_RSP) && !rst_enm;
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? w_ext : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_ram_byte_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_ram_byte_seq : scoreboard bench for ram_byte_seq with a byte-array model
// Revision        : 1.0  initial release
// ============================================================================
module tb_ram_byte_seq;
   localparam int DEPTH = 32;
   localparam int AW    = 32;

   logic          clk;
   logic          rst_enm;
   logic          req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]    req_size;
   logic [AW-1:0] req_addr;
   logic [31:0]   req_wdata;
   logic          rsp_valid, rsp_err;
   logic [31:0]   rsp_rdata;
   logic          mem_rd, mem_wr;
   logic [7:0]    mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_rdata;

   ram_byte_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_enm(rst_enm),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
   typedef struct { logic wr; logic [31:0] addr; logic [7:0] data; int cyc; } op_t;

   rsp_t       rsp_q[$];
   op_t        op_q[$];
   rsp_t       mon_rsp;
   op_t        mon_op;
   logic [7:0] ref_mem [0:DEPTH-1];
   logic [7:0] ram     [0:DEPTH-1];
   logic       ram_init;
   logic       mon_en  = 1'b0;
   int         cyc     = 0;
   int         n_pass  = 0;
   int         n_total = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37 + 11) ^ 8'h5A);
   endfunction

   // Registered-read byte RAM seen by the DUT.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= init_byte(i);
         mem_rdata <= 32'd0;
      end else begin
         if (mem_wr && mem_addr < DEPTH) ram[mem_addr[4:0]] <= mem_wdata;
         if (mem_rd && mem_addr < DEPTH) mem_rdata <= {24'hA5C3E1, ram[mem_addr[4:0]]};
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
         if (!mem_wr) chk("wdata_idle_zero", 32'(mem_wdata), 32'd0);
         if (mem_rd || mem_wr) begin
            if (op_q.size() == 0) begin
               chk("mem_op_unexpected", {30'd0, mem_rd, mem_wr}, 32'd0);
            end else begin
               mon_op = op_q.pop_front();
               chk("mem_op_wr", 32'(mem_wr), 32'(mon_op.wr));
               chk("mem_op_addr", mem_addr, mon_op.addr);
               if (mon_op.wr) chk("mem_op_wdata", 32'(mem_wdata), 32'(mon_op.data));
               chk("mem_op_cycle", 32'(cyc), 32'(mon_op.cyc));
            end
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
               mon_rsp = rsp_q.pop_front();
               chk("rsp_rdata", rsp_rdata, mon_rsp.rdata);
               chk("rsp_err", 32'(rsp_err), 32'(mon_rsp.err));
               chk("rsp_cycle", 32'(cyc), 32'(mon_rsp.cyc));
            end
         end
      end
   end

   // Drive one request, wait for acceptance, and record the expected bus ops and response.
   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input bit hold, output int acc);
      int          n;
      bit          err;
      bit          done;
      logic [31:0] val;
      acc  = -1;
      done = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      for (int w = 0; w < 40 && !done; w++) begin
         if (req_ready) begin
            acc  = cyc;
            done = 1'b1;
            n    = (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 1;
            err  = (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0)
                || (sz == 2'd2 && addr % 4 != 0) || (longint'(addr) + n - 1 >= DEPTH);
            if (err) begin
               rsp_q.push_back('{32'd0, 1'b1, acc + 1});
            end else if (we) begin
               for (int k = 0; k < n; k++) begin
                  op_q.push_back('{1'b1, 32'(addr + k), wd[8*k +: 8], acc + 1 + k});
                  ref_mem[32'(addr + k)] = wd[8*k +: 8];
               end
               rsp_q.push_back('{32'd0, 1'b0, acc + n + 1});
            end else begin
               val = 32'd0;
               for (int k = 0; k < n; k++) begin
                  op_q.push_back('{1'b0, 32'(addr + k), 8'd0, acc + 1 + k});
                  val = val + (32'(ref_mem[32'(addr + k)]) << (8 * k));
               end
               if (!uns && n == 1 && val >= 128)   val = val + 32'hFFFF_FF00;
               if (!uns && n == 2 && val >= 32768) val = val + 32'hFFFF_0000;
               rsp_q.push_back('{val, 1'b0, acc + n + 2});
            end
            @(posedge clk);
            #1;
            if (!hold) req_valid = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) begin
         chk("req_accept_timeout", 32'(req_ready), 32'd1);
         req_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int w = 0;
      while ((rsp_q.size() != 0 || op_q.size() != 0) && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("drain_pending", 32'(rsp_q.size() + op_q.size()), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int          a1, a2, a3;
      logic [7:0]  saved;
      logic [31:0] ra;
      logic [1:0]  rs;
      rst_enm = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'd0; ram_init = 1'b1;
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_mem_rd", 32'(mem_rd), 32'd0);
      chk("reset_mem_wr", 32'(mem_wr), 32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      @(posedge clk);
      #1;
      rst_enm  = 1'b0;
      ram_init = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(req_ready), 32'd1);
      mon_en = 1'b1;

      // Directed cases: store/load round trip, extensions, error and boundary addresses.
      issue(1'b1, 2'd2, 1'b0, 32'h08, 32'hA1B2C3D4, 1'b0, a1);
      issue(1'b0, 2'd2, 1'b0, 32'h08, 32'd0, 1'b0, a1);
      issue(1'b0, 2'd0, 1'b0, 32'h09, 32'd0, 1'b0, a1);
      issue(1'b0, 2'd0, 1'b1, 32'h09, 32'd0, 1'b0, a1);
      issue(1'b0, 2'd1, 1'b0, 32'h0A, 32'd0, 1'b0, a1);
      issue(1'b0, 2'd2, 1'b0, 32'h06, 32'd0, 1'b0, a1);
      issue(1'b1, 2'd1, 1'b0, 32'h03, 32'h5555, 1'b0, a1);
      issue(1'b0, 2'd3, 1'b0, 32'h00, 32'd0, 1'b0, a1);
      issue(1'b0, 2'd2, 1'b0, 32'h1E, 32'd0, 1'b0, a1);
      issue(1'b1, 2'd2, 1'b0, 32'h1C, 32'h11223344, 1'b0, a1);
      issue(1'b0, 2'd2, 1'b1, 32'h1C, 32'd0, 1'b0, a1);
      drain();

      // Reset during the third byte of a word store.
      saved = ref_mem[8'h13];
      issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0, a1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_enm = 1'b1;
      void'(rsp_q.pop_back());
      void'(op_q.pop_back());
      ref_mem[8'h13] = saved;
      @(negedge clk);
      chk("ready_during_reset", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_enm = 1'b0;
      @(negedge clk);
      chk("abort_mem_wr", 32'(mem_wr), 32'd0);
      chk("abort_mem_rd", 32'(mem_rd), 32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      issue(1'b1, 2'd0, 1'b0, 32'h05, 32'h00000077, 1'b0, a1);
      issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b0, a1);
      issue(1'b0, 2'd0, 1'b1, 32'h05, 32'd0, 1'b0, a1);
      drain();

      // Back-to-back with req_valid held high.
      issue(1'b1, 2'd2, 1'b0, 32'h14, $urandom(), 1'b1, a1);
      issue(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, 1'b1, a2);
      chk("b2b_store_to_load", 32'(a2 - a1), 32'd6);
      issue(1'b0, 2'd3, 1'b0, 32'h00, 32'd0, 1'b1, a3);
      chk("b2b_load_to_err", 32'(a3 - a2), 32'd7);
      issue(1'b0, 2'd0, 1'b1, 32'h04, 32'd0, 1'b0, a1);
      chk("b2b_err_to_byte", 32'(a1 - a3), 32'd2);
      drain();

      for (int i = 0; i < 250; i++) begin
         rs = 2'($urandom_range(0, 3));
         ra = 32'($urandom_range(0, 35));
         if ($urandom_range(0, 1) == 1) ra = ra & ~32'((rs == 2'd1) ? 1 : (rs == 2'd2) ? 3 : 0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         issue(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom(), 1'b0, a1);
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ram_byte_seq.md
Name: ram_byte_seq

Overview:
Initiator-side controller for the byte-wide data RAM. It accepts one load/store request (byte, half or word) from the core's memory stage. It sequences that request into single-byte RAM accesses, assembles little-endian load data, and returns one response pulse. It sits between the LSU request interface and the RAM's rd/wr/data/address pins.

Parameters:
DEPTH, 32, RAM size in bytes; any access touching an address >= DEPTH is an error.
AW, 32, width of the request and RAM byte address.

Ports:
clk  in  1  clock, all logic on posedge
rst_enm  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept; transfer when req_valid && req_ready
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  load extension: 1 = zero-extend, 0 = sign-extend
req_addr  in  AW  byte address
req_wdata  in  32  store data; byte k is bits [8k+7:8k]
rsp_valid  out  1  one-cycle response pulse; no backpressure
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  qualified by rsp_valid
mem_rd  out  1  RAM read strobe
mem_wr  out  1  RAM write strobe
mem_wdata  out  8  RAM write byte
mem_addr  out  AW  RAM byte address
mem_rdata  in  32  RAM registered read data; only [7:0] used

Behaviour:
- Reset (rst_enm sampled high): state IDLE, byte counter 0, all outputs 0 (req_ready 0 during the reset cycle, 1 from the next cycle).
- Reset mid-transaction aborts it. No rsp_valid is produced. mem_rd and mem_wr are 0 from the following cycle. Bytes already written are not undone.
- N = 1, 2 or 4 for size 00, 01 or 10. All RAM-side outputs are registered.
- States: IDLE, WR, RD, DRAIN, RSP.
- IDLE: req_ready = 1. On acceptance, latch addr, size, we, unsigned and wdata.
- Error check at acceptance: size 11; half with addr[0] = 1; word with addr[1:0] != 0; or addr + N - 1 >= DEPTH. On error, go straight to RSP with rsp_err = 1 and rsp_rdata = 0. No mem_rd/mem_wr is issued.
- Otherwise go to WR (store) or RD (load).
- WR: cycle k (k = 0..N-1 after acceptance) drives mem_wr = 1, mem_addr = addr + k, mem_wdata = wdata[8k+7:8k]. After byte N-1, go to RSP.
- RD: cycle k drives mem_rd = 1, mem_addr = addr + k. The RAM presents mem[addr+k] on mem_rdata one cycle later.
- Read capture: the byte issued in cycle k is captured at the end of cycle k+1 into assembly byte k. Issue and capture overlap.
- After the last issue, go to DRAIN for one cycle to capture byte N-1, then go to RSP.
- RSP: rsp_valid = 1 for exactly one cycle; next state IDLE. req_ready = 0 in every state except IDLE.
- Load extension: byte loads extend bit 7 and half loads extend bit 15 (sign) or fill zeros (unsigned). Word loads ignore req_unsigned.
- Latency, counted from the acceptance edge to the rsp_valid cycle: store N+1 cycles; load N+2 cycles; error 1 cycle.
- Word-store throughput: a new request is accepted every 6 cycles.
- mem_wdata is 0 whenever mem_wr = 0. mem_addr holds its last value when idle.
- Never assert mem_rd and mem_wr in the same cycle.
- Address arithmetic is AW-bit. Wrap-around cannot occur, because the DEPTH check rejects it first.

Test Plan:
- Word store addr 0x08, wdata 0xA1B2C3D4: mem_wr high 4 cycles, addr 8/9/10/11 with data D4/C3/B2/A1. Then rsp_valid 1 cycle, err 0, rdata 0.
- Word load addr 0x08 after the store above: mem_rd high 4 cycles, rsp_valid at acceptance + 6, rsp_rdata 0xA1B2C3D4, err 0.
- Byte load addr 0x09 (0xC3): signed gives rsp_rdata 0xFFFFFFC3; unsigned gives 0x000000C3. Half signed load addr 0x0A gives 0xFFFFA1B2.
- Errors, each giving rsp_err = 1 at acceptance + 1 with no mem_rd/mem_wr: word addr 0x06; half addr 0x03; size 11; word addr 0x1E (exceeds DEPTH 32). Word addr 0x1C is accepted and accesses bytes 0x1C..0x1F.
- Reset asserted for 1 cycle during the 3rd byte of a word store: no rsp_valid, mem_wr low next cycle, req_ready high the cycle after reset. A following byte store then completes normally.
- Back-to-back requests with req_valid held high: req_ready low for the whole transaction. Second request accepted only in the cycle after rsp_valid.
